// File: rtl/effect_pkg.sv
// Shared types and constants for the player effect scheduler.
// Timers are 13 bits wide; energy is 11 bits.
package effect_pkg;

   localparam int unsigned TIMER_W   = 13;
   localparam int unsigned ENERGY_W  = 11;
   localparam int unsigned TIMER_MAX = (1 << TIMER_W) - 1;

   localparam int unsigned DEF_TICK_DIV    = 100_000;
   localparam int unsigned DEF_POWER_MS    = 5000;
   localparam int unsigned DEF_COOLDOWN_MS = 1000;
   localparam int unsigned DEF_CURSE_MS    = 3000;
   localparam int unsigned DEF_ENERGY_MAX  = 1000;
   localparam int unsigned DEF_DRAIN_MS    = 10;
   localparam int unsigned DEF_RECHARGE_MS = 20;

   typedef enum logic [1:0] {P_IDLE, P_ACTIVE, P_COOLDOWN} power_state_t;
   typedef enum logic {C_IDLE, C_ACTIVE} curse_state_t;

   function automatic bit fits_timer(input int unsigned v);
      return v <= TIMER_MAX;
   endfunction

endpackage

// File: rtl/effect_scheduler_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
// Holds its count while en is low.
module tick_prescaler #(
   parameter int unsigned DIV = 100_000
) (
   input  logic sysclk,
   input  logic reset_n,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge sysclk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/effect_scheduler.sv
// Power-up / curse effect timers and player energy counter feeding the
// speed selector. All durations are counted in prescaled ms ticks.
module effect_scheduler
   import effect_pkg::*;
#(
   parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
   parameter int unsigned POWER_MS    = DEF_POWER_MS,
   parameter int unsigned COOLDOWN_MS = DEF_COOLDOWN_MS,
   parameter int unsigned CURSE_MS    = DEF_CURSE_MS,
   parameter int unsigned ENERGY_MAX  = DEF_ENERGY_MAX,
   parameter int unsigned DRAIN_MS    = DEF_DRAIN_MS,
   parameter int unsigned RECHARGE_MS = DEF_RECHARGE_MS
) (
   input  logic        sysclk,
   input  logic        reset_n,
   input  logic        en,
   input  logic        pickup_power,
   input  logic        pickup_curse,
   input  logic        moving,
   output logic        power_up_active,
   output logic        curse_active,
   output logic [10:0] energy,
   output logic        curse_blocked,
   output logic [12:0] power_left
);

   if (!fits_timer(POWER_MS) || !fits_timer(COOLDOWN_MS) || !fits_timer(CURSE_MS) ||
       !fits_timer(DRAIN_MS) || !fits_timer(RECHARGE_MS) || ENERGY_MAX >= 2048) begin : g_param_err
      $error("effect_scheduler: parameter out of range for timer/energy width");
   end

   localparam logic [TIMER_W-1:0]  ONE        = TIMER_W'(1);
   localparam logic [TIMER_W-1:0]  POWER_T    = TIMER_W'(POWER_MS);
   localparam logic [TIMER_W-1:0]  COOL_T     = TIMER_W'(COOLDOWN_MS);
   localparam logic [TIMER_W-1:0]  CURSE_T    = TIMER_W'(CURSE_MS);
   localparam logic [TIMER_W-1:0]  DRAIN_T    = TIMER_W'(DRAIN_MS);
   localparam logic [TIMER_W-1:0]  DRAIN_HALF = TIMER_W'(DRAIN_MS / 2);
   localparam logic [TIMER_W-1:0]  RECH_T     = TIMER_W'(RECHARGE_MS);
   localparam logic [ENERGY_W-1:0] EMAX       = ENERGY_W'(ENERGY_MAX);

   logic tick;

   tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
      .sysclk  (sysclk),
      .reset_n (reset_n),
      .en      (en),
      .tick    (tick)
   );

   power_state_t        p_state_q, p_state_d;
   curse_state_t        c_state_q, c_state_d;
   logic [TIMER_W-1:0]  p_tmr_q, p_tmr_d;
   logic [TIMER_W-1:0]  c_tmr_q, c_tmr_d;
   logic [TIMER_W-1:0]  acc_q, acc_d;
   logic [ENERGY_W-1:0] energy_q, energy_d;
   logic                mode_q, mode_d;
   logic                blocked_q, blocked_d;

   logic               power_take, curse_blk, curse_take;
   logic [TIMER_W-1:0] drain_lim;

   always_comb begin
      p_state_d = p_state_q;
      p_tmr_d   = p_tmr_q;
      c_state_d = c_state_q;
      c_tmr_d   = c_tmr_q;
      acc_d     = acc_q;
      energy_d  = energy_q;
      mode_d    = mode_q;

      power_take = en && pickup_power && (p_state_q != P_COOLDOWN);
      // A power pickup in the same cycle already grants immunity.
      curse_blk  = en && pickup_curse && ((p_state_q == P_ACTIVE) || power_take);
      curse_take = en && pickup_curse && !curse_blk;
      blocked_d  = curse_blk;
      drain_lim  = (c_state_q == C_ACTIVE) ? DRAIN_HALF : DRAIN_T;

      if (power_take) begin
         p_state_d = P_ACTIVE;
         p_tmr_d   = POWER_T;
      end else if (tick) begin
         case (p_state_q)
            P_ACTIVE: begin
               if (p_tmr_q == ONE) begin
                  p_state_d = P_COOLDOWN;
                  p_tmr_d   = COOL_T;
               end else begin
                  p_tmr_d = p_tmr_q - ONE;
               end
            end
            P_COOLDOWN: begin
               if (p_tmr_q == ONE) begin
                  p_state_d = P_IDLE;
                  p_tmr_d   = '0;
               end else begin
                  p_tmr_d = p_tmr_q - ONE;
               end
            end
            default: ;
         endcase
      end

      if (power_take) begin
         c_state_d = C_IDLE;
         c_tmr_d   = '0;
      end else if (curse_take) begin
         c_state_d = C_ACTIVE;
         c_tmr_d   = CURSE_T;
      end else if (tick && c_state_q == C_ACTIVE) begin
         if (c_tmr_q == ONE) begin
            c_state_d = C_IDLE;
            c_tmr_d   = '0;
         end else begin
            c_tmr_d = c_tmr_q - ONE;
         end
      end

      // Accumulator holds while moving under power so drain resumes in phase.
      if (en) begin
         mode_d = moving;
         if (moving != mode_q) begin
            acc_d = '0;
         end else if (tick) begin
            if (moving) begin
               if (p_state_q != P_ACTIVE) begin
                  if (acc_q + ONE >= drain_lim) begin
                     acc_d = '0;
                     if (energy_q != '0) energy_d = energy_q - ENERGY_W'(1);
                  end else begin
                     acc_d = acc_q + ONE;
                  end
               end
            end else if (acc_q + ONE >= RECH_T) begin
               acc_d = '0;
               if (energy_q < EMAX) energy_d = energy_q + ENERGY_W'(1);
            end else begin
               acc_d = acc_q + ONE;
            end
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (!reset_n) begin
         p_state_q <= P_IDLE;
         c_state_q <= C_IDLE;
         p_tmr_q   <= '0;
         c_tmr_q   <= '0;
         acc_q     <= '0;
         energy_q  <= EMAX;
         mode_q    <= 1'b0;
         blocked_q <= 1'b0;
      end else begin
         p_state_q <= p_state_d;
         c_state_q <= c_state_d;
         p_tmr_q   <= p_tmr_d;
         c_tmr_q   <= c_tmr_d;
         acc_q     <= acc_d;
         energy_q  <= energy_d;
         mode_q    <= mode_d;
         blocked_q <= blocked_d;
      end
   end

   assign power_up_active = (p_state_q == P_ACTIVE);
   assign power_left      = (p_state_q == P_ACTIVE) ? p_tmr_q : '0;
   assign curse_active    = (c_state_q == C_ACTIVE);
   assign energy          = energy_q;
   assign curse_blocked   = blocked_q;

endmodule

// File: tb/tb_effect_scheduler.sv
// Scoreboard bench for effect_scheduler: stimulus queues expected output
// values tagged with a target cycle; a negedge monitor checks and retires them.
module tb_effect_scheduler;

   localparam int F_PUA = 0, F_CA = 1, F_EN = 2, F_PL = 3, F_CB = 4;

   logic        sysclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en = 1'b1;
   logic        pickup_power = 1'b0;
   logic        pickup_curse = 1'b0;
   logic        moving = 1'b0;
   logic        power_up_active;
   logic        curse_active;
   logic [10:0] energy;
   logic        curse_blocked;
   logic [12:0] power_left;

   effect_scheduler #(
      .TICK_DIV    (4),
      .POWER_MS    (5),
      .COOLDOWN_MS (3),
      .CURSE_MS    (4),
      .ENERGY_MAX  (20),
      .DRAIN_MS    (2),
      .RECHARGE_MS (3)
   ) dut (
      .sysclk          (sysclk),
      .reset_n         (reset_n),
      .en              (en),
      .pickup_power    (pickup_power),
      .pickup_curse    (pickup_curse),
      .moving          (moving),
      .power_up_active (power_up_active),
      .curse_active    (curse_active),
      .energy          (energy),
      .curse_blocked   (curse_blocked),
      .power_left      (power_left)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      int    tgt;
      int    fld;
      int    val;
      string name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   drain = 1'b0;
   bit   reported = 1'b0;

   always @(posedge sysclk) cyc <= cyc + 1;

   function automatic int field_val(input int f);
      case (f)
         F_PUA:   return int'(power_up_active);
         F_CA:    return int'(curse_active);
         F_EN:    return int'(energy);
         F_PL:    return int'(power_left);
         default: return int'(curse_blocked);
      endcase
   endfunction

   always @(negedge sysclk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].tgt == cyc) begin
            n_tests++;
            if (field_val(sb[i].fld) != sb[i].val) begin
               n_fail++;
               $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                        sb[i].name, field_val(sb[i].fld), sb[i].val, cyc);
            end
            sb.delete(i);
         end
      end
      if (drain && !reported) begin
         foreach (sb[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never sampled, expected %0d at cycle %0d", sb[i].name, sb[i].val, sb[i].tgt);
         end
         sb.delete();
         reported = 1'b1;
      end
   end

   task automatic expect_at(input int k, input int fld, input int val, input string name);
      exp_t e;
      e.tgt  = cyc + k;
      e.fld  = fld;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic wait_edges(input int k);
      repeat (k) @(posedge sysclk);
      #2;
   endtask

   task automatic expect_reset_vals(input int k, input string tag);
      expect_at(k, F_PUA, 0, {tag, "_pua"});
      expect_at(k, F_CA, 0, {tag, "_ca"});
      expect_at(k, F_EN, 20, {tag, "_energy"});
      expect_at(k, F_PL, 0, {tag, "_left"});
      expect_at(k, F_CB, 0, {tag, "_blocked"});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      en = 1'b1;
      pickup_power = 1'b0;
      pickup_curse = 1'b0;
      moving = 1'b0;
      wait_edges(2);
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power lifecycle: pickup at edge 10, ticks on every 4th edge after reset
      do_reset();
      expect_reset_vals(0, "reset");
      wait_edges(9);
      pickup_power = 1'b1;
      expect_at(1, F_PUA, 1, "life_rise");
      expect_at(1, F_PL, 5, "life_left5");
      wait_edges(1);
      pickup_power = 1'b0;
      expect_at(17, F_PUA, 1, "life_last_tick");
      expect_at(17, F_PL, 1, "life_left1");
      expect_at(18, F_PUA, 0, "life_fall");
      expect_at(18, F_PL, 0, "life_left0");
      wait_edges(19);
      pickup_power = 1'b1;
      expect_at(1, F_PUA, 0, "cooldown_ignore");
      wait_edges(1);
      pickup_power = 1'b0;
      wait_edges(10);
      pickup_power = 1'b1;
      expect_at(1, F_PUA, 1, "after_cooldown_rise");
      expect_at(1, F_PL, 5, "after_cooldown_left");
      wait_edges(1);
      pickup_power = 1'b0;

      // Extend: reload at power_left==2
      do_reset();
      pickup_power = 1'b1;
      wait_edges(1);
      pickup_power = 1'b0;
      expect_at(11, F_PL, 2, "extend_before");
      wait_edges(11);
      pickup_power = 1'b1;
      expect_at(1, F_PL, 5, "extend_reload");
      wait_edges(1);
      pickup_power = 1'b0;
      expect_at(18, F_PUA, 1, "extend_still_on");
      expect_at(18, F_PL, 1, "extend_left1");
      expect_at(19, F_PUA, 0, "extend_off");
      wait_edges(20);

      // Immunity, curse in cooldown, curse reload, cleanse
      do_reset();
      pickup_power = 1'b1;
      wait_edges(1);
      pickup_power = 1'b0;
      pickup_curse = 1'b1;
      expect_at(1, F_CB, 1, "immune_blocked");
      expect_at(1, F_CA, 0, "immune_no_curse");
      wait_edges(1);
      pickup_curse = 1'b0;
      expect_at(1, F_CB, 0, "immune_pulse_end");
      wait_edges(18);
      pickup_curse = 1'b1;
      expect_at(1, F_CA, 1, "curse_in_cooldown");
      expect_at(1, F_CB, 0, "curse_not_blocked");
      wait_edges(1);
      pickup_curse = 1'b0;
      wait_edges(11);
      pickup_curse = 1'b1;
      expect_at(1, F_CA, 1, "curse_reload");
      wait_edges(1);
      pickup_curse = 1'b0;
      expect_at(3, F_CA, 1, "curse_timer3");
      wait_edges(3);
      pickup_power = 1'b1;
      expect_at(1, F_CA, 0, "cleanse");
      expect_at(1, F_PUA, 1, "cleanse_power");
      wait_edges(1);
      pickup_power = 1'b0;

      // Simultaneous pickups from idle
      do_reset();
      pickup_power = 1'b1;
      pickup_curse = 1'b1;
      expect_at(1, F_PUA, 1, "simul_power");
      expect_at(1, F_CA, 0, "simul_curse");
      expect_at(1, F_CB, 1, "simul_blocked");
      wait_edges(1);
      pickup_power = 1'b0;
      pickup_curse = 1'b0;

      // Energy: drain 10 ticks, then recharge and saturate
      do_reset();
      moving = 1'b1;
      wait_edges(1);
      expect_at(38, F_EN, 16, "drain_9ticks");
      expect_at(39, F_EN, 15, "drain_10ticks");
      wait_edges(39);
      moving = 1'b0;
      expect_at(35, F_EN, 17, "recharge_8ticks");
      expect_at(36, F_EN, 18, "recharge_9ticks");
      expect_at(59, F_EN, 19, "recharge_19");
      expect_at(72, F_EN, 20, "recharge_saturate");
      wait_edges(74);

      // Energy: cursed drain down to zero and hold
      do_reset();
      moving = 1'b1;
      pickup_curse = 1'b1;
      wait_edges(1);
      pickup_curse = 1'b0;
      expect_at(38, F_EN, 11, "curse_drain_9");
      expect_at(39, F_EN, 10, "curse_drain_10");
      expect_at(75, F_EN, 1, "curse_drain_to1");
      expect_at(79, F_EN, 0, "curse_drain_to0");
      expect_at(87, F_EN, 0, "curse_drain_hold0");
      for (int i = 0; i < 7; i++) begin
         wait_edges(11);
         pickup_curse = 1'b1;
         wait_edges(1);
         pickup_curse = 1'b0;
      end
      wait_edges(4);

      // Energy: moving under power holds, drain resumes in cooldown
      do_reset();
      pickup_power = 1'b1;
      moving = 1'b1;
      expect_at(20, F_EN, 20, "power_hold");
      expect_at(28, F_EN, 19, "power_resume_drain");
      wait_edges(1);
      pickup_power = 1'b0;
      wait_edges(28);

      // en low mid-power freezes everything and ignores pickups
      do_reset();
      pickup_power = 1'b1;
      wait_edges(1);
      pickup_power = 1'b0;
      wait_edges(4);
      en = 1'b0;
      pickup_curse = 1'b1;
      expect_at(1, F_CB, 0, "en_low_no_block");
      expect_at(1, F_CA, 0, "en_low_no_curse");
      wait_edges(1);
      pickup_curse = 1'b0;
      expect_at(24, F_PL, 4, "en_low_hold_mid");
      expect_at(49, F_PL, 4, "en_low_hold_end");
      expect_at(49, F_EN, 20, "en_low_energy");
      wait_edges(49);
      en = 1'b1;
      expect_at(2, F_PL, 4, "en_resume_before");
      expect_at(3, F_PL, 3, "en_resume_tick");
      wait_edges(4);

      // Reset mid-curse overrides all state
      do_reset();
      moving = 1'b1;
      pickup_curse = 1'b1;
      wait_edges(1);
      pickup_curse = 1'b0;
      expect_at(7, F_EN, 18, "pre_reset_energy");
      expect_at(7, F_CA, 1, "pre_reset_curse");
      wait_edges(7);
      reset_n = 1'b0;
      expect_reset_vals(1, "midreset");
      wait_edges(1);
      reset_n = 1'b1;
      moving = 1'b0;

      wait_edges(2);
      drain = 1'b1;
      for (int i = 0; i < 10 && !reported; i++) @(posedge sysclk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
